// File: rtl/rv32_pipeline_ctrl_pkg.sv
// Shared types for the rv32 pipeline sequencer: FSM states, the per-stage command bundle and the reset PC.
package rv32_pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_RESUME = 2'd3
    } pipe_ctrl_state_t;

    typedef struct packed {
        logic fetch_hold;
        logic pc_load;
        logic decode_set_nop;
        logic exec_bubble;
        logic pipe_freeze;
    } pipe_cmd_t;

    localparam logic [31:0] RV32_RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/rv32_pipeline_ctrl_perf_counters.sv
// Free-running stall/flush/halt event counters; wrap modulo 2^32, cleared by synchronous reset.
module rv32_pipe_perf_counters (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall_evt,
    input  logic        i_flush_evt,
    input  logic        i_halt_evt,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt,
    output logic [31:0] o_halt_cnt
);
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_halt_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_halt_cnt  <= '0;
        end else begin
            if (i_stall_evt) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (i_flush_evt) r_flush_cnt <= r_flush_cnt + 32'd1;
            if (i_halt_evt)  r_halt_cnt  <= r_halt_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
    assign o_halt_cnt  = r_halt_cnt;
endmodule

// File: rtl/rv32_pipeline_ctrl.sv
// Pipeline sequencer: turns stall/redirect/mem-wait/halt events into per-stage hold/bubble/flush commands.
// Performance counters are built only when RV32_PIPE_PERF_EN is defined; otherwise the count ports read 0.
module rv32_pipeline_ctrl
    import rv32_pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RV32_RESET_PC_DEFAULT,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_decode_stall,
    input  logic        i_exec_redirect,
    input  logic [31:0] i_exec_redirect_pc,
    input  logic        i_mem_busy,
    input  logic        i_halt_req,
    input  logic        i_resume_req,
    input  logic [31:0] i_fetch_pc,
    output logic        o_fetch_hold,
    output logic        o_pc_load,
    output logic [31:0] o_pc_load_val,
    output logic        o_decode_set_nop,
    output logic [31:0] o_decode_set_nop_pc,
    output logic        o_exec_bubble,
    output logic        o_pipe_freeze,
    output logic        o_halted,
    output logic        o_halt_ack,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt,
    output logic [31:0] o_halt_cnt
);
    localparam logic [3:0] LP_DRAIN = 4'(DRAIN_CYCLES);

    pipe_ctrl_state_t r_state, w_state_nxt;
    logic [3:0]       r_drain_cnt, w_drain_cnt_nxt;
    logic [31:0]      r_resume_pc, w_resume_pc_nxt;
    pipe_cmd_t        w_cmd;
    logic [31:0]      w_pc_load_val;
    logic [31:0]      w_nop_pc;
    logic             w_halt_ack;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_resume_pc <= RESET_PC;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_resume_pc <= w_resume_pc_nxt;
        end
    end

    // A redirect always wins the resume PC, even while the pipe is frozen.
    assign w_resume_pc_nxt = i_exec_redirect ? i_exec_redirect_pc :
                             (r_state == ST_RUN && i_halt_req && !i_mem_busy) ? i_fetch_pc :
                             r_resume_pc;

    always_comb begin
        w_cmd           = '0;
        w_pc_load_val   = '0;
        w_nop_pc        = '0;
        w_halt_ack      = 1'b0;
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        if (i_reset) begin
            w_cmd.fetch_hold     = 1'b1;
            w_cmd.decode_set_nop = 1'b1;
            w_cmd.exec_bubble    = 1'b1;
            w_cmd.pc_load        = 1'b1;
            w_pc_load_val        = RESET_PC;
            w_nop_pc             = RESET_PC;
        end else if (i_mem_busy) begin
            w_cmd.pipe_freeze = 1'b1;
            w_cmd.fetch_hold  = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_exec_redirect) begin
                        w_cmd.pc_load        = 1'b1;
                        w_pc_load_val        = i_exec_redirect_pc;
                        w_cmd.decode_set_nop = 1'b1;
                        w_nop_pc             = i_exec_redirect_pc;
                    end else if (i_decode_stall) begin
                        w_cmd.fetch_hold  = 1'b1;
                        w_cmd.exec_bubble = 1'b1;
                    end
                    if (i_halt_req) begin
                        w_state_nxt     = ST_DRAIN;
                        w_drain_cnt_nxt = LP_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    w_cmd.fetch_hold     = 1'b1;
                    w_cmd.decode_set_nop = 1'b1;
                    w_nop_pc             = r_resume_pc;
                    if (r_drain_cnt == 4'd0) begin
                        w_state_nxt = ST_HALTED;
                        w_halt_ack  = 1'b1;
                    end else begin
                        w_drain_cnt_nxt = r_drain_cnt - 4'd1;
                    end
                end
                ST_HALTED: begin
                    w_cmd.fetch_hold     = 1'b1;
                    w_cmd.decode_set_nop = 1'b1;
                    w_nop_pc             = r_resume_pc;
                    if (i_resume_req) w_state_nxt = ST_RESUME;
                end
                ST_RESUME: begin
                    w_cmd.pc_load = 1'b1;
                    w_pc_load_val = r_resume_pc;
                    w_state_nxt   = ST_RUN;
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    assign o_fetch_hold        = w_cmd.fetch_hold;
    assign o_pc_load           = w_cmd.pc_load;
    assign o_pc_load_val       = w_pc_load_val;
    assign o_decode_set_nop    = w_cmd.decode_set_nop;
    assign o_decode_set_nop_pc = w_nop_pc;
    assign o_exec_bubble       = w_cmd.exec_bubble;
    assign o_pipe_freeze       = w_cmd.pipe_freeze;
    assign o_halted            = !i_reset && (r_state == ST_HALTED);
    assign o_halt_ack          = w_halt_ack;

`ifdef RV32_PIPE_PERF_EN
    logic w_stall_evt;
    logic w_flush_evt;
    logic w_halt_evt;

    assign w_stall_evt = i_mem_busy || (r_state == ST_RUN && !i_exec_redirect && i_decode_stall);
    assign w_flush_evt = i_exec_redirect;
    assign w_halt_evt  = (r_state == ST_HALTED);

    rv32_pipe_perf_counters u_perf (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_stall_evt (w_stall_evt),
        .i_flush_evt (w_flush_evt),
        .i_halt_evt  (w_halt_evt),
        .o_stall_cnt (o_stall_cnt),
        .o_flush_cnt (o_flush_cnt),
        .o_halt_cnt  (o_halt_cnt)
    );
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
    assign o_halt_cnt  = '0;
`endif
endmodule

// File: tb/tb_rv32_pipeline_ctrl.sv
// Scoreboard bench for rv32_pipeline_ctrl: directed scenarios followed by random traffic against a behavioural model.
module tb_rv32_pipeline_ctrl;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          NDRAIN = 3;
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2, M_RESUME = 3;

    typedef struct packed {
        logic        fh;
        logic        pl;
        logic [31:0] plv;
        logic        nop;
        logic [31:0] noppc;
        logic        bub;
        logic        frz;
        logic        hlt;
        logic        ack;
        logic [31:0] sc;
        logic [31:0] fc;
        logic [31:0] hc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, decode_stall, exec_redirect, mem_busy, halt_req, resume_req;
    logic [31:0] exec_redirect_pc, fetch_pc;
    logic        fetch_hold, pc_load, decode_set_nop, exec_bubble, pipe_freeze, halted, halt_ack;
    logic [31:0] pc_load_val, decode_set_nop_pc, stall_cnt, flush_cnt, halt_cnt;

    int n_vec  = 0;
    int n_miss = 0;
    exp_t sb_q[$];

    // Reference model state
    int          m_mode = M_RUN;
    int          m_drain_left = 0;
    logic [31:0] m_resume = RST_PC;
    logic [31:0] m_sc = 0, m_fc = 0, m_hc = 0;
    logic        last_ack = 1'b0;

    always #5 clk = ~clk;

    rv32_pipeline_ctrl #(.RESET_PC(RST_PC), .DRAIN_CYCLES(NDRAIN)) dut (
        .i_clk(clk), .i_reset(reset), .i_decode_stall(decode_stall),
        .i_exec_redirect(exec_redirect), .i_exec_redirect_pc(exec_redirect_pc),
        .i_mem_busy(mem_busy), .i_halt_req(halt_req), .i_resume_req(resume_req),
        .i_fetch_pc(fetch_pc),
        .o_fetch_hold(fetch_hold), .o_pc_load(pc_load), .o_pc_load_val(pc_load_val),
        .o_decode_set_nop(decode_set_nop), .o_decode_set_nop_pc(decode_set_nop_pc),
        .o_exec_bubble(exec_bubble), .o_pipe_freeze(pipe_freeze), .o_halted(halted),
        .o_halt_ack(halt_ack), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt),
        .o_halt_cnt(halt_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle, so each negedge consumes one expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("fetch_hold", 32'(fetch_hold), 32'(e.fh));
            chk("pc_load", 32'(pc_load), 32'(e.pl));
            if (e.pl) chk("pc_load_val", pc_load_val, e.plv);
            chk("decode_set_nop", 32'(decode_set_nop), 32'(e.nop));
            if (e.nop) chk("decode_set_nop_pc", decode_set_nop_pc, e.noppc);
            chk("exec_bubble", 32'(exec_bubble), 32'(e.bub));
            chk("pipe_freeze", 32'(pipe_freeze), 32'(e.frz));
            chk("halted", 32'(halted), 32'(e.hlt));
            chk("halt_ack", 32'(halt_ack), 32'(e.ack));
            chk("stall_cnt", stall_cnt, e.sc);
            chk("flush_cnt", flush_cnt, e.fc);
            chk("halt_cnt", halt_cnt, e.hc);
        end
    end

    // One clock of stimulus: predict this cycle's outputs, queue them, then advance the model on the edge.
    task automatic step(input logic rst, input logic ds, input logic rd, input logic [31:0] rdpc,
                        input logic mb, input logic hr, input logic rr);
        exp_t e;
        reset = rst; decode_stall = ds; exec_redirect = rd; exec_redirect_pc = rdpc;
        mem_busy = mb; halt_req = hr; resume_req = rr; fetch_pc = $urandom;
        e = '0;
`ifdef RV32_PIPE_PERF_EN
        e.sc = m_sc; e.fc = m_fc; e.hc = m_hc;
`endif
        e.hlt = !rst && (m_mode == M_HALTED);
        if (rst) begin
            e.fh = 1; e.nop = 1; e.bub = 1; e.pl = 1; e.plv = RST_PC; e.noppc = RST_PC;
        end else if (mb) begin
            e.frz = 1; e.fh = 1;
        end else if (m_mode == M_RUN) begin
            if (rd) begin
                e.pl = 1; e.plv = rdpc; e.nop = 1; e.noppc = rdpc;
            end else if (ds) begin
                e.fh = 1; e.bub = 1;
            end
        end else if (m_mode == M_DRAIN) begin
            e.fh = 1; e.nop = 1; e.noppc = m_resume; e.ack = (m_drain_left == 0);
        end else if (m_mode == M_HALTED) begin
            e.fh = 1; e.nop = 1; e.noppc = m_resume;
        end else begin
            e.pl = 1; e.plv = m_resume;
        end
        last_ack = e.ack;
        sb_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            m_mode = M_RUN; m_drain_left = 0; m_resume = RST_PC;
            m_sc = 0; m_fc = 0; m_hc = 0;
        end else begin
            if (mb || (m_mode == M_RUN && !rd && ds)) m_sc = m_sc + 1;
            if (rd) m_fc = m_fc + 1;
            if (m_mode == M_HALTED) m_hc = m_hc + 1;
            if (rd) m_resume = rdpc;
            else if (m_mode == M_RUN && hr && !mb) m_resume = fetch_pc;
            if (!mb) begin
                case (m_mode)
                    M_RUN:    if (hr) begin m_mode = M_DRAIN; m_drain_left = NDRAIN; end
                    M_DRAIN:  if (m_drain_left == 0) m_mode = M_HALTED; else m_drain_left--;
                    M_HALTED: if (rr) m_mode = M_RESUME;
                    default:  m_mode = M_RUN;
                endcase
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic halt_until_ack(input int budget);
        int k;
        k = 0;
        while (!last_ack && k < budget) begin
            step(0, 0, 0, 32'h0, 0, 1, 0);
            k++;
        end
        chk("halt_ack_reached", 32'(last_ack), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hr_active;
        logic rst, ds, rd, mb, rr;
        reset = 1; decode_stall = 0; exec_redirect = 0; exec_redirect_pc = 0;
        mem_busy = 0; halt_req = 0; resume_req = 0; fetch_pc = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0, 0, 0, 0);
        idle(2);
        step(0, 1, 0, 32'h0, 0, 0, 0);
        step(0, 1, 0, 32'h0, 0, 0, 0);
        step(0, 1, 1, 32'h0000_0100, 0, 0, 0);
        idle(1);

        // Halt with a redirect landing in the second drain cycle, then resume.
        step(0, 0, 0, 32'h0, 0, 1, 0);
        step(0, 0, 0, 32'h0, 0, 1, 0);
        step(0, 0, 1, 32'h0000_0200, 0, 1, 0);
        halt_until_ack(10);
        idle(3);
        step(0, 0, 0, 32'h0, 0, 0, 1);
        idle(3);

        // mem_busy in mid-drain stretches the drain.
        step(0, 0, 0, 32'h0, 0, 1, 0);
        step(0, 0, 0, 32'h0, 0, 1, 0);
        step(0, 0, 0, 32'h0, 1, 1, 0);
        step(0, 0, 0, 32'h0, 1, 1, 0);
        halt_until_ack(10);
        idle(2);

        // Reset while halted.
        step(1, 0, 0, 32'h0, 0, 0, 0);
        step(1, 0, 0, 32'h0, 0, 0, 0);
        idle(3);

        hr_active = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            ds  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            mb  = ($urandom_range(0, 7) == 0);
            rr  = (m_mode == M_HALTED) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            if (!hr_active && m_mode == M_RUN && $urandom_range(0, 15) == 0) hr_active = 1;
            step(rst, ds, rd, $urandom, mb, hr_active, rr);
            if (last_ack || rst) hr_active = 0;
        end
        idle(2);

        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
